// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses imem and fills the IF/ID register.
// A BOOT/RUN/HALT FSM handles start-up, stalls, redirects, flushes and fetches past the end of imem.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 201,
   parameter logic [31:0] NOP_INSTR  = 32'hE1A0_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pcplus8_d,
   output logic        valid_d,
   output logic        halted,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

   state_t      state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic [31:0] instr_d_q, instr_d_d;
   logic [31:0] pc_d_q, pc_d_d;
   logic [31:0] pcplus8_d_q, pcplus8_d_d;
   logic        valid_d_q, valid_d_d;
   logic        halted_q, halted_d;
   logic [31:0] fetch_count_q, fetch_count_d;

   logic [31:0] target_aligned;
   logic        out_of_range;

   // Masking keeps the target word-aligned so pc_f[1:0] stays zero.
   assign target_aligned = redirect_target & 32'hFFFF_FFFC;
   assign out_of_range   = (pc_f_q[31:2] >= IMEM_LIMIT);

   always_comb begin
      state_d       = state_q;
      pc_f_d        = pc_f_q;
      instr_d_d     = instr_d_q;
      pc_d_d        = pc_d_q;
      pcplus8_d_d   = pcplus8_d_q;
      valid_d_d     = valid_d_q;
      halted_d      = halted_q;
      fetch_count_d = fetch_count_q;

      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (redirect) begin
               pc_f_d    = target_aligned;
               instr_d_d = NOP_INSTR;
               valid_d_d = 1'b0;
            end else if (out_of_range) begin
               state_d  = HALT;
               halted_d = 1'b1;
               if (!stall) begin
                  instr_d_d = NOP_INSTR;
                  valid_d_d = 1'b0;
               end
            end else if (stall) begin
               if (flush) begin
                  instr_d_d = NOP_INSTR;
                  valid_d_d = 1'b0;
               end
            end else if (flush) begin
               instr_d_d = NOP_INSTR;
               valid_d_d = 1'b0;
               pc_f_d    = pc_f_q + 32'd4;
            end else begin
               instr_d_d   = imem_rd;
               pc_d_d      = pc_f_q;
               pcplus8_d_d = pc_f_q + 32'd8;
               valid_d_d   = 1'b1;
               pc_f_d      = pc_f_q + 32'd4;
               if (fetch_count_q != 32'hFFFF_FFFF) begin
                  fetch_count_d = fetch_count_q + 32'd1;
               end
            end
         end
         HALT: begin
            if (!stall) begin
               instr_d_d = NOP_INSTR;
               valid_d_d = 1'b0;
            end
            // An out-of-range target simply falls back into HALT on the next RUN cycle.
            if (redirect) begin
               pc_f_d   = target_aligned;
               halted_d = 1'b0;
               state_d  = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= BOOT;
         pc_f_q        <= RESET_PC;
         instr_d_q     <= NOP_INSTR;
         pc_d_q        <= 32'd0;
         pcplus8_d_q   <= 32'd0;
         valid_d_q     <= 1'b0;
         halted_q      <= 1'b0;
         fetch_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_f_q        <= pc_f_d;
         instr_d_q     <= instr_d_d;
         pc_d_q        <= pc_d_d;
         pcplus8_d_q   <= pcplus8_d_d;
         valid_d_q     <= valid_d_d;
         halted_q      <= halted_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign imem_a      = pc_f_q;
   assign instr_d     = instr_d_q;
   assign pc_d        = pc_d_q;
   assign pcplus8_d   = pcplus8_d_q;
   assign valid_d     = valid_d_q;
   assign halted      = halted_q;
   assign fetch_count = fetch_count_q;

endmodule
